// File: rtl/codec_config_sequencer.sv
// rtl/codec_config_sequencer.sv - walks the codec init table, then forwards host register writes, over i2c_controller
// Define CODEC_STARTUP_DELAY_EN to insert a STARTUP_DELAY-cycle power-up wait before the first init pass.
module codec_config_sequencer #(
  parameter logic [6:0] CODEC_ADDR    = 7'h1A,
  parameter int         INIT_LEN      = 11,
  parameter int         TIMEOUT       = 4096,
  parameter int         STARTUP_DELAY = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_host_req,
  input  logic [6:0] i_host_reg,
  input  logic [8:0] i_host_data,
  output logic       o_host_ack,
  output logic       o_init_done,
  output logic       o_busy,
  output logic       o_error,
  output logic [3:0] o_entry_idx,
  output logic       o_i2c_enable,
  output logic       o_i2c_mode,
  output logic [6:0] o_i2c_periph_addr,
  output logic [7:0] o_i2c_transmit_byte,
  input  logic       i_i2c_ready
);
  localparam int         TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(INIT_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, ISSUE, WAIT_ACCEPT, WAIT_DONE, NEXT, READY, ERROR
`ifdef CODEC_STARTUP_DELAY_EN
    , DELAY
`endif
  } state_t;

  // Table entry packed as {register[6:0], data[8:0]}
  function automatic logic [15:0] f_table(input logic [3:0] idx);
    case (idx)
      4'd0:    f_table = {7'h0F, 9'h000};
      4'd1:    f_table = {7'h06, 9'h000};
      4'd2:    f_table = {7'h00, 9'h017};
      4'd3:    f_table = {7'h01, 9'h017};
      4'd4:    f_table = {7'h02, 9'h079};
      4'd5:    f_table = {7'h03, 9'h079};
      4'd6:    f_table = {7'h04, 9'h012};
      4'd7:    f_table = {7'h05, 9'h000};
      4'd8:    f_table = {7'h07, 9'h042};
      4'd9:    f_table = {7'h08, 9'h000};
      4'd10:   f_table = {7'h09, 9'h001};
      default: f_table = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] f_byte(input logic [6:0] reg_a, input logic [8:0] data, input logic ph);
    f_byte = ph ? data[7:0] : {reg_a, data[8]};
  endfunction

  state_t          r_state;
  logic            r_phase;
  logic            r_host_mode;
  logic [6:0]      r_host_reg;
  logic [8:0]      r_host_data;
  logic [TW-1:0]   r_timer;
  logic [3:0]      r_entry_idx;
  logic            r_init_done;
  logic            r_error;
  logic            r_host_ack;
  logic            r_enable;
  logic [7:0]      r_byte;

  logic [15:0] w_entry;
  logic [15:0] w_next_entry;
  logic [15:0] w_first;
  logic [6:0]  w_cur_reg;
  logic [8:0]  w_cur_data;
  logic        w_timeout;
  logic        w_restart;

  assign w_entry      = f_table(r_entry_idx);
  assign w_next_entry = f_table(r_entry_idx + 4'd1);
  assign w_first      = f_table(4'd0);
  assign w_cur_reg    = r_host_mode ? r_host_reg  : w_entry[15:9];
  assign w_cur_data   = r_host_mode ? r_host_data : w_entry[8:0];
  assign w_timeout    = (r_timer == TW'(TIMEOUT - 1));
  assign w_restart    = i_start && (r_state inside {IDLE, READY, ERROR});

`ifdef CODEC_STARTUP_DELAY_EN
  localparam int DW = $clog2(STARTUP_DELAY + 1);
  logic [DW-1:0] r_delay;
`else
  logic w_unused_delay;
  assign w_unused_delay = (STARTUP_DELAY != 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_phase     <= 1'b0;
      r_host_mode <= 1'b0;
      r_host_reg  <= '0;
      r_host_data <= '0;
      r_timer     <= '0;
      r_entry_idx <= '0;
      r_init_done <= 1'b0;
      r_error     <= 1'b0;
      r_host_ack  <= 1'b0;
      r_enable    <= 1'b0;
      r_byte      <= '0;
`ifdef CODEC_STARTUP_DELAY_EN
      r_delay     <= '0;
`endif
    end else begin
      r_enable   <= 1'b0;
      r_host_ack <= 1'b0;
      if (w_restart) begin
        r_entry_idx <= '0;
        r_phase     <= 1'b0;
        r_host_mode <= 1'b0;
        r_init_done <= 1'b0;
        r_error     <= 1'b0;
        r_timer     <= '0;
        r_byte      <= f_byte(w_first[15:9], w_first[8:0], 1'b0);
`ifdef CODEC_STARTUP_DELAY_EN
        r_delay     <= '0;
        r_state     <= (r_state == IDLE) ? DELAY : LOAD;
`else
        r_state     <= LOAD;
`endif
      end else begin
        case (r_state)
          LOAD: begin
            if (i_i2c_ready) begin
              r_enable <= 1'b1;
              r_state  <= ISSUE;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          ISSUE: begin
            r_timer <= '0;
            r_state <= WAIT_ACCEPT;
          end
          WAIT_ACCEPT: begin
            if (!i_i2c_ready) begin
              r_timer <= '0;
              r_state <= WAIT_DONE;
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          WAIT_DONE: begin
            if (i_i2c_ready) begin
              r_timer <= '0;
              if (!r_phase) begin
                r_phase <= 1'b1;
                r_byte  <= f_byte(w_cur_reg, w_cur_data, 1'b1);
                r_state <= LOAD;
              end else begin
                r_host_ack <= r_host_mode;
                r_state    <= NEXT;
              end
            end else if (w_timeout) begin
              r_error <= 1'b1;
              r_state <= ERROR;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
          NEXT: begin
            r_phase <= 1'b0;
            if (r_host_mode) begin
              r_state <= READY;
            end else if (r_entry_idx == LAST_IDX) begin
              r_init_done <= 1'b1;
              r_state     <= READY;
            end else begin
              r_entry_idx <= r_entry_idx + 4'd1;
              r_byte      <= f_byte(w_next_entry[15:9], w_next_entry[8:0], 1'b0);
              r_timer     <= '0;
              r_state     <= LOAD;
            end
          end
          READY: begin
            if (i_host_req) begin
              r_host_reg  <= i_host_reg;
              r_host_data <= i_host_data;
              r_host_mode <= 1'b1;
              r_phase     <= 1'b0;
              r_byte      <= f_byte(i_host_reg, i_host_data, 1'b0);
              r_timer     <= '0;
              r_state     <= LOAD;
            end
          end
`ifdef CODEC_STARTUP_DELAY_EN
          DELAY: begin
            if (r_delay == DW'(STARTUP_DELAY - 1)) begin
              r_timer <= '0;
              r_state <= LOAD;
            end else begin
              r_delay <= r_delay + DW'(1);
            end
          end
`endif
          IDLE, ERROR: r_state <= r_state;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy              = !(r_state inside {IDLE, READY, ERROR});
  assign o_host_ack          = r_host_ack;
  assign o_init_done         = r_init_done;
  assign o_error             = r_error;
  assign o_entry_idx         = r_entry_idx;
  assign o_i2c_enable        = r_enable;
  assign o_i2c_mode          = 1'b1;
  assign o_i2c_periph_addr   = CODEC_ADDR;
  assign o_i2c_transmit_byte = r_byte;
endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb/tb_codec_config_sequencer.sv - byte-stream scoreboard bench for codec_config_sequencer
module tb_codec_config_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       host_req = 1'b0;
  logic [6:0] host_reg = '0;
  logic [8:0] host_data = '0;
  logic       host_ack, init_done, busy, error_o, i2c_enable, i2c_mode;
  logic [3:0] entry_idx;
  logic [6:0] periph_addr;
  logic [7:0] tx_byte;
  logic       i2c_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  codec_config_sequencer #(.CODEC_ADDR(7'h1A), .INIT_LEN(11), .TIMEOUT(64), .STARTUP_DELAY(100)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_host_req(host_req),
    .i_host_reg(host_reg), .i_host_data(host_data), .o_host_ack(host_ack),
    .o_init_done(init_done), .o_busy(busy), .o_error(error_o), .o_entry_idx(entry_idx),
    .o_i2c_enable(i2c_enable), .o_i2c_mode(i2c_mode), .o_i2c_periph_addr(periph_addr),
    .o_i2c_transmit_byte(tx_byte), .i_i2c_ready(i2c_ready)
  );

  int tbl_r [11] = '{'h0F, 'h06, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h07, 'h08, 'h09};
  int tbl_d [11] = '{'h000, 'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h042, 'h000, 'h001};

  logic [7:0] exp_q [$];
  logic [7:0] byte_log [$];
  int         exp_acks = 0;
  int         ack_seen = 0;
  bit         ctl_stuck = 1'b0;
  int         ctl_cnt = 0;
  logic       en_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_entry(input int r, input int d);
    exp_q.push_back(8'((r * 2 + d / 256) % 256));
    exp_q.push_back(8'(d % 256));
  endtask

  task automatic push_init();
    for (int i = 0; i < 11; i++) push_entry(tbl_r[i], tbl_d[i]);
  endtask

  task automatic push_host(input int r, input int d);
    push_entry(r, d);
    exp_acks++;
  endtask

  // Controller: ready drops on the second cycle after the enable, returns 20 cycles later
  always @(negedge clk) begin
    if (!rst_n) begin
      i2c_ready = 1'b1;
      ctl_cnt = 0;
    end else if (ctl_cnt == 0) begin
      if (i2c_enable && !ctl_stuck) ctl_cnt = 1;
    end else begin
      ctl_cnt++;
      if (ctl_cnt == 2) i2c_ready = 1'b0;
      else if (ctl_cnt == 22) begin
        i2c_ready = 1'b1;
        ctl_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mode", 32'(i2c_mode), 32'd1);
      chk("addr", 32'(periph_addr), 32'h1A);
      if (i2c_enable) begin
        chk("en_single_cycle", 32'(en_prev), 32'd0);
        chk("en_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) chk("byte", 32'(tx_byte), 32'(exp_q.pop_front()));
        byte_log.push_back(tx_byte);
      end
      if (host_ack) begin
        ack_seen++;
        chk("ack_expected", 32'(exp_acks > 0), 32'd1);
        chk("ack_after_bytes", 32'(exp_q.size()), 32'd0);
        if (exp_acks > 0) exp_acks--;
      end
      en_prev = i2c_enable;
    end else begin
      en_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_settle(input int lim, input string nm);
    int n = 0;
    while ((busy || !(init_done || error_o)) && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < lim), 32'd1);
  endtask

  task automatic wait_ack(input int lim, input string nm);
    int n = 0;
    while (!host_ack && n < lim) begin
      tick();
      n++;
    end
    chk(nm, 32'(n < lim), 32'd1);
    chk({nm, "_init_done"}, 32'(init_done), 32'd1);
    host_req = 1'b0;
  endtask

  initial begin
    int n;
    int acks0;
    int log0;
    repeat (3) tick();
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_en", 32'(i2c_enable), 32'd0);
    chk("rst_idx", 32'(entry_idx), 32'd0);
    chk("rst_byte", 32'(tx_byte), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Full init, measuring start-to-first-enable latency
    push_init();
    start = 1'b1;
    n = 0;
    while (!i2c_enable && n < 2000) begin
      tick();
      start = 1'b0;
      n++;
    end
`ifdef CODEC_STARTUP_DELAY_EN
    chk("first_en_delayed", 32'(n >= 100 && n < 2000), 32'd1);
`else
    chk("first_en_fast", 32'(n <= 3), 32'd1);
`endif
    wait_settle(3000, "init_settle");
    chk("init_done", 32'(init_done), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_error", 32'(error_o), 32'd0);
    chk("init_idx", 32'(entry_idx), 32'd10);
    chk("init_all_issued", 32'(exp_q.size()), 32'd0);
    chk("init_count", 32'(byte_log.size()), 32'd22);
    if (byte_log.size() >= 22) begin
      chk("lit_b0", 32'(byte_log[0]), 32'h1E);
      chk("lit_b1", 32'(byte_log[1]), 32'h00);
      chk("lit_b2", 32'(byte_log[2]), 32'h0C);
      chk("lit_b5", 32'(byte_log[5]), 32'h17);
      chk("lit_b20", 32'(byte_log[20]), 32'h12);
      chk("lit_b21", 32'(byte_log[21]), 32'h01);
    end

    // Runtime host write
    acks0 = ack_seen;
    push_host('h02, 'h17F);
    host_reg = 7'h02;
    host_data = 9'h17F;
    host_req = 1'b1;
    wait_ack(500, "host1_ack");
    repeat (30) tick();
    chk("host1_ack_once", 32'(ack_seen - acks0), 32'd1);
    chk("host1_busy", 32'(busy), 32'd0);
    chk("host1_init_done", 32'(init_done), 32'd1);
    if (byte_log.size() >= 24) begin
      chk("lit_h0", 32'(byte_log[22]), 32'h05);
      chk("lit_h1", 32'(byte_log[23]), 32'h7F);
    end

    // Host request raised during init waits for init to finish
    push_init();
    push_host('h05, 'h0AA);
    pulse_start();
    chk("restart_clears_done", 32'(init_done), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    host_reg = 7'h05;
    host_data = 9'h0AA;
    host_req = 1'b1;
    wait_ack(3000, "host2_ack");
    wait_settle(200, "host2_settle");

    // Start and host request together in READY: start wins
    push_init();
    push_host('h04, 'h1FF);
    host_reg = 7'h04;
    host_data = 9'h1FF;
    host_req = 1'b1;
    pulse_start();
    chk("sim_init_restart", 32'(init_done), 32'd0);
    wait_ack(3000, "host3_ack");
    wait_settle(200, "host3_settle");

    // Controller never accepts: timeout into ERROR on entry 0
    ctl_stuck = 1'b1;
    push_init();
    log0 = byte_log.size();
    pulse_start();
    n = 1;
    while (!error_o && n < 500) begin
      tick();
      n++;
    end
    chk("to_window", 32'(n >= 64 && n <= 70), 32'd1);
    chk("to_error", 32'(error_o), 32'd1);
    chk("to_idx", 32'(entry_idx), 32'd0);
    chk("to_one_byte", 32'(byte_log.size() - log0), 32'd1);
    repeat (10) tick();
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_sticky", 32'(error_o), 32'd1);
    exp_q.delete();
    ctl_stuck = 1'b0;
    push_init();
    pulse_start();
    chk("retry_clears_error", 32'(error_o), 32'd0);
    wait_settle(3000, "retry_settle");
    chk("retry_done", 32'(init_done), 32'd1);
    chk("retry_error", 32'(error_o), 32'd0);
    chk("retry_all_issued", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of entry 5
    push_init();
    pulse_start();
    n = 0;
    while (entry_idx != 4'd5 && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_idx5", 32'(n < 1000), 32'd1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(i2c_enable), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_idx", 32'(entry_idx), 32'd0);
    chk("mid_rst_byte", 32'(tx_byte), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    chk("mid_rst_error", 32'(error_o), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    log0 = byte_log.size();
    repeat (60) tick();
    chk("no_resume", 32'(byte_log.size() - log0), 32'd0);
    chk("no_resume_busy", 32'(busy), 32'd0);
    push_init();
    pulse_start();
    wait_settle(3000, "final_settle");
    chk("final_done", 32'(init_done), 32'd1);
    chk("final_all_issued", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
